// File: rtl/rv32_mem_arbiter_pkg.sv
// Shared definitions for the rv32 memory arbiter and its picker.
package rv32_mem_arbiter_pkg;

  typedef enum logic {
    BUS_RD = 1'b0,
    BUS_WR = 1'b1
  } bus_op_e;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 4;
  localparam int MAX_MASTERS    = 8;

  // Master ID width; a single master still carries a 1-bit ID.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv32_rr_pick.sv
// Combinational one-hot picker: round-robin from a pointer, or fixed
// priority with index 0 highest.
module rv32_rr_pick
  import rv32_mem_arbiter_pkg::*;
#(
  parameter  int NUM_REQ   = 2,
  parameter  int PRIO_MODE = 0,
  localparam int IDX_W     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  int   cand;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (PRIO_MODE != 0) ? i : int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = IDX_W'(cand);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// N-master to single-port memory arbiter: one access per cycle, reads
// returned to their issuer after RD_LATENCY cycles via a tag pipeline.
module rv32_mem_arbiter
  import rv32_mem_arbiter_pkg::*;
#(
  parameter  int NUM_MASTERS = 2,
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 32,
  parameter  int RD_LATENCY  = 1,
  parameter  int PRIO_MODE   = 0,
  localparam int ID_W        = id_width(NUM_MASTERS),
  localparam int BE_W        = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_wr,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS*BE_W-1:0]   m_be,
  output logic [NUM_MASTERS-1:0]        m_gnt,
  output logic [NUM_MASTERS-1:0]        m_rvalid,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          mem_rd,
  output logic                          mem_wr,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [BE_W-1:0]               mem_be,
  input  logic [DATA_W-1:0]             mem_rdata
);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } rd_tag_t;

  logic [NUM_MASTERS-1:0] req_live;
  logic [NUM_MASTERS-1:0] gnt;
  logic [ID_W-1:0]        gnt_idx;
  logic [ID_W-1:0]        ptr_q;
  logic                   any_gnt;
  bus_op_e                sel_op;

  rd_tag_t [RD_LATENCY-1:0] tag_q;

  // Requests are masked while in reset so nothing reaches the memory.
  assign req_live = m_req & {NUM_MASTERS{reset_n}};

  rv32_rr_pick #(
    .NUM_REQ   (NUM_MASTERS),
    .PRIO_MODE (PRIO_MODE)
  ) u_pick (
    .req     (req_live),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign any_gnt = |gnt;
  assign m_gnt   = gnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (any_gnt) begin
      ptr_q <= (gnt_idx == ID_W'(NUM_MASTERS - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  always_comb begin
    sel_op    = BUS_RD;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt[i]) begin
        sel_op    = bus_op_e'(m_wr[i]);
        mem_addr  = m_addr[i*ADDR_W +: ADDR_W];
        mem_wdata = m_wdata[i*DATA_W +: DATA_W];
        mem_be    = m_be[i*BE_W +: BE_W];
      end
    end
  end

  assign mem_rd = any_gnt && (sel_op == BUS_RD);
  assign mem_wr = any_gnt && (sel_op == BUS_WR);

  // One tag per cycle; the last stage lines up with mem_rdata.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= '{valid: mem_rd, id: gnt_idx};
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    m_rvalid = '0;
    if (tag_q[RD_LATENCY-1].valid) begin
      m_rvalid[tag_q[RD_LATENCY-1].id] = 1'b1;
    end
  end

  assign m_rdata = mem_rdata;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Bench for rv32_mem_arbiter: a round-robin instance (latency 2) and a
// fixed-priority instance (latency 3) driven by the same master stimulus.
module tb_rv32_mem_arbiter;

  localparam int LA = 2;
  localparam int LB = 3;
  localparam logic [31:0] KEY = 32'h5A5A_0F0F;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  m_req;
  logic [1:0]  m_wr;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_be;

  logic [1:0]  gnt_a, rvalid_a, gnt_b, rvalid_b;
  logic [31:0] rdata_a, maddr_a, mwdata_a, mem_rdata_a;
  logic [31:0] rdata_b, maddr_b, mwdata_b, mem_rdata_b;
  logic        mrd_a, mwr_a, mrd_b, mwr_b;
  logic [3:0]  mbe_a, mbe_b;

  logic [31:0] pa [LA];
  logic [31:0] pb [LB];

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rv32_mem_arbiter #(
    .NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .RD_LATENCY(LA), .PRIO_MODE(0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be), .m_gnt(gnt_a), .m_rvalid(rvalid_a),
    .m_rdata(rdata_a), .mem_rd(mrd_a), .mem_wr(mwr_a), .mem_addr(maddr_a),
    .mem_wdata(mwdata_a), .mem_be(mbe_a), .mem_rdata(mem_rdata_a)
  );

  rv32_mem_arbiter #(
    .NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .RD_LATENCY(LB), .PRIO_MODE(1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be), .m_gnt(gnt_b), .m_rvalid(rvalid_b),
    .m_rdata(rdata_b), .mem_rd(mrd_b), .mem_wr(mwr_b), .mem_addr(maddr_b),
    .mem_wdata(mwdata_b), .mem_be(mbe_b), .mem_rdata(mem_rdata_b)
  );

  // Memory models: data is a fixed function of the address issued LA/LB cycles ago.
  always @(posedge clk) begin
    pa[0] <= maddr_a;
    for (int i = 1; i < LA; i++) pa[i] <= pa[i-1];
    pb[0] <= maddr_b;
    for (int i = 1; i < LB; i++) pb[i] <= pb[i-1];
  end
  assign mem_rdata_a = pa[LA-1] ^ KEY;
  assign mem_rdata_b = pb[LB-1] ^ KEY;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Read responses: compare against the scoreboard head when it is due.
  always @(negedge clk) begin
    if (sb_a.size() > 0 && sb_a[0].cyc == cyc) begin
      chk("a.rvalid", 32'(rvalid_a), 32'(1) << sb_a[0].id);
      chk("a.rdata", rdata_a, sb_a[0].data);
      void'(sb_a.pop_front());
    end else begin
      chk("a.rvalid_idle", 32'(rvalid_a), 32'h0);
    end
    if (sb_b.size() > 0 && sb_b[0].cyc == cyc) begin
      chk("b.rvalid", 32'(rvalid_b), 32'(1) << sb_b[0].id);
      chk("b.rdata", rdata_b, sb_b[0].data);
      void'(sb_b.pop_front());
    end else begin
      chk("b.rvalid_idle", 32'(rvalid_b), 32'h0);
    end
  end

  task automatic bus_chk(input string s, input logic [1:0] g_exp, input logic [1:0] g_obs,
                         input logic rd_obs, input logic wr_obs, input logic [31:0] addr_obs,
                         input logic [31:0] wdata_obs, input logic [3:0] be_obs, input int lat,
                         output bit push, output exp_t e);
    logic [31:0] ea, ew;
    logic [3:0]  eb;
    logic        ewr;
    ea  = g_exp[1] ? m_addr[63:32]  : g_exp[0] ? m_addr[31:0]  : 32'h0;
    ew  = g_exp[1] ? m_wdata[63:32] : g_exp[0] ? m_wdata[31:0] : 32'h0;
    eb  = g_exp[1] ? m_be[7:4]      : g_exp[0] ? m_be[3:0]     : 4'h0;
    ewr = |(g_exp & m_wr);
    chk({s, ".gnt"},       32'(g_obs),  32'(g_exp));
    chk({s, ".mem_rd"},    32'(rd_obs), 32'((g_exp != 2'b00) && !ewr));
    chk({s, ".mem_wr"},    32'(wr_obs), 32'((g_exp != 2'b00) && ewr));
    chk({s, ".mem_addr"},  addr_obs,    ea);
    chk({s, ".mem_wdata"}, wdata_obs,   ew);
    chk({s, ".mem_be"},    32'(be_obs), 32'(eb));
    push  = (g_exp != 2'b00) && !ewr;
    e.id   = g_exp[1] ? 1 : 0;
    e.data = ea ^ KEY;
    e.cyc  = cyc + lat;
  endtask

  task automatic step(input logic [1:0] req, input logic [1:0] wr, input logic [31:0] a0,
                      input logic [31:0] a1, input logic [1:0] ega, input logic [1:0] egb);
    bit   push_a, push_b;
    exp_t e_a, e_b;
    @(posedge clk);
    #1;
    m_req  = req;
    m_wr   = wr;
    m_addr = {a1, a0};
    @(negedge clk);
    bus_chk("a", ega, gnt_a, mrd_a, mwr_a, maddr_a, mwdata_a, mbe_a, LA, push_a, e_a);
    bus_chk("b", egb, gnt_b, mrd_b, mwr_b, maddr_b, mwdata_b, mbe_b, LB, push_b, e_b);
    if (push_a) sb_a.push_back(e_a);
    if (push_b) sb_b.push_back(e_b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 2'b00);
  endtask

  initial begin
    bit   dummy;
    exp_t e_dummy;
    m_wdata = {32'h0BAD_F00D, 32'h1122_3344};
    m_be    = 8'hCC;
    m_wr    = 2'b00;
    m_addr  = {32'h0000_0AAA, 32'h0000_0555};
    m_req   = 2'b11;

    // Requests held during reset must not be granted or reach memory.
    @(negedge clk);
    bus_chk("rst_a", 2'b00, gnt_a, mrd_a, mwr_a, maddr_a, mwdata_a, mbe_a, LA, dummy, e_dummy);
    bus_chk("rst_b", 2'b00, gnt_b, mrd_b, mwr_b, maddr_b, mwdata_b, mbe_b, LB, dummy, e_dummy);
    m_req = 2'b00;
    @(posedge clk);
    #1 reset_n = 1'b1;

    idle(1);

    // Single read by m0.
    step(2'b01, 2'b00, 32'h10, 32'h0, 2'b01, 2'b01);
    idle(4);

    // Continuous contention: RR alternates (pointer is 1 after the read), priority keeps m0.
    for (int k = 0; k < 4; k++) begin
      step(2'b11, 2'b00, 32'h100 + 32'(4*k), 32'h200 + 32'(4*k),
           (k % 2 == 0) ? 2'b10 : 2'b01, 2'b01);
    end
    // m0 drops out: m1 finally wins on the priority instance.
    step(2'b10, 2'b00, 32'h0, 32'h300, 2'b10, 2'b10);
    idle(4);

    // Back-to-back m1 reads, fully pipelined.
    for (int k = 0; k < 4; k++) begin
      step(2'b10, 2'b00, 32'h0, 32'h400 + 32'(4*k), 2'b10, 2'b10);
    end
    idle(4);

    // m1 write with partial byte enables; no response expected.
    m_wdata = {32'hAABB_CCDD, 32'h1122_3344};
    m_be    = {4'b0011, 4'b1100};
    step(2'b10, 2'b10, 32'h0, 32'h500, 2'b10, 2'b10);
    idle(3);

    // Two reads in flight, RR pointer left at 1, then a reset pulse.
    step(2'b10, 2'b00, 32'h0, 32'h700, 2'b10, 2'b10);
    step(2'b01, 2'b00, 32'h704, 32'h0, 2'b01, 2'b01);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    m_req   = 2'b00;
    sb_a.delete();
    sb_b.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(5);
    // Pointer is back at 0: master 0 wins on both instances.
    step(2'b11, 2'b00, 32'h800, 32'h804, 2'b01, 2'b01);
    idle(4);

    chk("a.sb_drained", 32'(sb_a.size()), 32'h0);
    chk("b.sb_drained", 32'(sb_b.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
